// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Brief    : STAGES-deep carry-lookahead adder/subtractor with valid/ready.
//            Macro PIPELINED_CLA_ADDER_SAT_EN saturates S on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================

module pipelined_cla_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] S,
    output logic             cout,
    output logic             overflow
);

    localparam int c_SW   = WIDTH / STAGES;
    localparam int c_NN   = c_SW / 4;
    localparam int c_LAST = STAGES - 1;

    // Returns {carry out, carry into slice MSB, slice sum}.
    function automatic logic [c_SW+1:0] f_cla_slice(
        input logic [c_SW-1:0] a,
        input logic [c_SW-1:0] b,
        input logic            ci
    );
        logic [c_SW-1:0] g;
        logic [c_SW-1:0] p;
        logic [c_SW-1:0] c;
        logic [c_NN-1:0] ng;
        logic [c_NN-1:0] np;
        logic [c_NN:0]   nc;
        logic            t;
        logic            pp;
        g = a & b;
        p = a ^ b;
        for (int n = 0; n < c_NN; n++) begin
            ng[n] = g[4*n+3]
                  | (p[4*n+3] & g[4*n+2])
                  | (p[4*n+3] & p[4*n+2] & g[4*n+1])
                  | ((&p[4*n+1 +: 3]) & g[4*n]);
            np[n] = &p[4*n +: 4];
        end
        // Group lookahead: each nibble carry is a flat sum of products.
        nc[0] = ci;
        for (int n = 0; n < c_NN; n++) begin
            t  = ng[n];
            pp = np[n];
            for (int j = n - 1; j >= 0; j--) begin
                t  = t | (pp & ng[j]);
                pp = pp & np[j];
            end
            nc[n+1] = t | (pp & ci);
        end
        for (int n = 0; n < c_NN; n++) begin
            c[4*n] = nc[n];
            for (int i = 1; i < 4; i++) begin
                t  = g[4*n+i-1];
                pp = p[4*n+i-1];
                for (int j = i - 2; j >= 0; j--) begin
                    t  = t | (pp & g[4*n+j]);
                    pp = pp & p[4*n+j];
                end
                c[4*n+i] = t | (pp & nc[n]);
            end
        end
        return {nc[c_NN], c[c_SW-1], p ^ c};
    endfunction

    logic [WIDTH-1:0] w_a0;
    logic [WIDTH-1:0] w_b0;
    logic             w_ci0;
    logic             w_adv;
    logic             w_ovf;
    logic [WIDTH-1:0] w_s_fin;
    logic [WIDTH-1:0] w_xin [STAGES];
    logic [WIDTH-1:0] w_yin [STAGES];
    logic             w_cin [STAGES];
    logic             w_vin [STAGES];
    logic [c_SW+1:0]  w_res [STAGES];
    logic [WIDTH-1:0] w_xnx [STAGES];

    // r_x holds resolved sum slices below the stage and pending A slices above.
    logic [WIDTH-1:0] r_x [STAGES];
    logic [WIDTH-1:0] r_y [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;

    assign w_a0  = A;
    assign w_b0  = sub ? ~B : B;
    assign w_ci0 = sub | cin;
    assign w_adv = !r_v[c_LAST] | out_ready;

    always_comb begin
        w_xin[0] = w_a0;
        w_yin[0] = w_b0;
        w_cin[0] = w_ci0;
        w_vin[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_xin[k] = r_x[k-1];
            w_yin[k] = r_y[k-1];
            w_cin[k] = r_c[k-1];
            w_vin[k] = r_v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_res[k] = f_cla_slice(w_xin[k][k*c_SW +: c_SW],
                                   w_yin[k][k*c_SW +: c_SW],
                                   w_cin[k]);
            w_xnx[k] = w_xin[k];
            w_xnx[k][k*c_SW +: c_SW] = w_res[k][c_SW-1:0];
        end
    end

    assign w_ovf = w_res[c_LAST][c_SW+1] ^ w_res[c_LAST][c_SW];

`ifdef PIPELINED_CLA_ADDER_SAT_EN
    // A's sign bit is still in w_xin of the last stage: its slice is unresolved.
    always_comb begin
        w_s_fin = w_xnx[c_LAST];
        if (w_ovf) begin
            w_s_fin = w_xin[c_LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_s_fin = w_xnx[c_LAST];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_vin[k];
                r_y[k] <= w_yin[k];
                r_c[k] <= w_res[k][c_SW+1];
                r_x[k] <= (k == c_LAST) ? w_s_fin : w_xnx[k];
            end
            r_ovf <= w_ovf;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_v[c_LAST];
    assign S         = r_x[c_LAST];
    assign cout      = r_c[c_LAST];
    assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// Bench for pipelined_cla_adder: a 16-bit/2-stage and a 32-bit/4-stage instance
// exercised with directed vectors and a reference-model sweep.

module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        iv16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0, ordy16 = 1'b1;
    logic        ir16, ov16, co16, of16;
    logic [15:0] a16 = '0, b16 = '0, s16;

    logic        iv32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0, ordy32 = 1'b1;
    logic        ir32, ov32, co32, of32;
    logic [31:0] a32 = '0, b32 = '0, s32;

    pipelined_cla_adder #(.WIDTH(16), .STAGES(2)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .cin(cin16), .sub(sub16),
        .out_valid(ov16), .out_ready(ordy16), .S(s16), .cout(co16), .overflow(of16)
    );

    pipelined_cla_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .A(a32), .B(b32), .cin(cin32), .sub(sub32),
        .out_valid(ov32), .out_ready(ordy32), .S(s32), .cout(co32), .overflow(of32)
    );

    task automatic send16(input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          output logic [15:0] s, output logic co, output logic of,
                          output int lat);
        a16 = a; b16 = b; cin16 = ci; sub16 = sb; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat  = 1;
        while (!ov16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = s16; co = co16; of = of16;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb,
                          output logic [31:0] s, output logic co, output logic of,
                          output int lat);
        a32 = a; b32 = b; cin32 = ci; sub32 = sb; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat  = 1;
        while (!ov32 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = s32; co = co32; of = of32;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_cmp++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", ov16); end
        n_cmp++; if (s16 !== 16'h0000) begin n_fail++; $display("FAIL reset_S got=%h exp=0000", s16); end
        n_cmp++; if (co16 !== 1'b0 || of16 !== 1'b0) begin n_fail++; $display("FAIL reset_flags cout=%b ovf=%b exp=0/0", co16, of16); end
        n_cmp++; if (ov32 !== 1'b0 || s32 !== 32'h0) begin n_fail++; $display("FAIL reset_wide ov=%b S=%h exp=0/0", ov32, s32); end
        rst = 1'b0;
        #1;
        n_cmp++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", ir16); end
    endtask

    task automatic test_add();
        logic [15:0] s, e;
        logic        co, of;
        int          lat;
        send16(16'h5555, 16'h5555, 1'b0, 1'b0, s, co, of, lat);
`ifdef PIPELINED_CLA_ADDER_SAT_EN
        e = 16'h7FFF;
`else
        e = 16'hAAAA;
`endif
        n_cmp++; if (s !== e) begin n_fail++; $display("FAIL add_5555_S got=%h exp=%h", s, e); end
        n_cmp++; if (co !== 1'b0 || of !== 1'b1) begin n_fail++; $display("FAIL add_5555_flags cout=%b ovf=%b exp=0/1", co, of); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL add_5555_latency got=%0d exp=2", lat); end

        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, of, lat);
        n_cmp++; if (s !== 16'h0000) begin n_fail++; $display("FAIL add_ffff_S got=%h exp=0000", s); end
        n_cmp++; if (co !== 1'b1 || of !== 1'b0) begin n_fail++; $display("FAIL add_ffff_flags cout=%b ovf=%b exp=1/0", co, of); end

        send16(16'h1234, 16'h1111, 1'b1, 1'b0, s, co, of, lat);
        n_cmp++; if (s !== 16'h2346 || co !== 1'b0) begin n_fail++; $display("FAIL add_cin_S got=%h/%b exp=2346/0", s, co); end

        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, of, lat);
`ifdef PIPELINED_CLA_ADDER_SAT_EN
        e = 16'h7FFF;
`else
        e = 16'h8000;
`endif
        n_cmp++; if (s !== e || co !== 1'b0 || of !== 1'b1) begin n_fail++; $display("FAIL add_posovf got S=%h cout=%b ovf=%b exp S=%h cout=0 ovf=1", s, co, of, e); end
    endtask

    task automatic test_sub();
        logic [15:0] s, e;
        logic        co, of;
        int          lat;
        send16(16'h0003, 16'h0005, 1'b1, 1'b1, s, co, of, lat);
        n_cmp++; if (s !== 16'hFFFE) begin n_fail++; $display("FAIL sub_3m5_S got=%h exp=fffe", s); end
        n_cmp++; if (co !== 1'b0 || of !== 1'b0) begin n_fail++; $display("FAIL sub_3m5_flags cout=%b ovf=%b exp=0/0", co, of); end

        send16(16'h0005, 16'h0003, 1'b0, 1'b1, s, co, of, lat);
        n_cmp++; if (s !== 16'h0002 || co !== 1'b1) begin n_fail++; $display("FAIL sub_5m3 got=%h/%b exp=0002/1", s, co); end

        send16(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, of, lat);
`ifdef PIPELINED_CLA_ADDER_SAT_EN
        e = 16'h8000;
`else
        e = 16'h7FFF;
`endif
        n_cmp++; if (s !== e || co !== 1'b1 || of !== 1'b1) begin n_fail++; $display("FAIL sub_negovf got S=%h cout=%b ovf=%b exp S=%h cout=1 ovf=1", s, co, of, e); end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        a16 = 16'h00FF; b16 = 16'h0001;
        @(posedge clk); #1;
        iv16 = 1'b0; ordy16 = 1'b0;
        n_cmp++; if (ov16 !== 1'b1 || s16 !== 16'h0002) begin n_fail++; $display("FAIL b2b_first got ov=%b S=%h exp 1/0002", ov16, s16); end
        if (ov16 === 1'b1) got++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (ov16 !== 1'b1 || s16 !== 16'h0002 || ir16 !== 1'b0) begin
                n_fail++; $display("FAIL b2b_stall%0d got ov=%b S=%h in_ready=%b exp 1/0002/0", i, ov16, s16, ir16);
            end
        end
        ordy16 = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ov16 !== 1'b1 || s16 !== 16'h0100 || co16 !== 1'b0) begin n_fail++; $display("FAIL b2b_second got ov=%b S=%h cout=%b exp 1/0100/0", ov16, s16, co16); end
        if (ov16 === 1'b1) got++;
        @(posedge clk); #1;
        if (ov16 === 1'b1) got++;
        @(posedge clk); #1;
        if (ov16 === 1'b1) got++;
        n_cmp++; if (got !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", got); end
    endtask

    task automatic test_async_reset();
        logic [15:0] s;
        logic        co, of;
        int          lat;
        a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        a16 = 16'h00FF;
        @(posedge clk); #1;
        iv16 = 1'b0;
        n_cmp++; if (ov16 !== 1'b1) begin n_fail++; $display("FAIL arst_pre got ov=%b exp=1", ov16); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (ov16 !== 1'b0 || s16 !== 16'h0000) begin n_fail++; $display("FAIL arst_immediate got ov=%b S=%h exp 0/0000", ov16, s16); end
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL arst_stale%0d got ov=%b S=%h exp ov=0", i, ov16, s16); end
        end
        send16(16'h1234, 16'h1111, 1'b0, 1'b0, s, co, of, lat);
        n_cmp++; if (s !== 16'h2345 || lat !== 2) begin n_fail++; $display("FAIL arst_after got S=%h lat=%0d exp 2345/2", s, lat); end
    endtask

    task automatic test_wide_directed();
        logic [31:0] s, e;
        logic        co, of;
        int          lat;
        send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, co, of, lat);
        n_cmp++; if (s !== 32'h0 || co !== 1'b1 || of !== 1'b0) begin n_fail++; $display("FAIL w_ripple got S=%h cout=%b ovf=%b exp 0/1/0", s, co, of); end
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL w_latency got=%0d exp=4", lat); end
        send32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, s, co, of, lat);
        n_cmp++; if (s !== 32'hACF1_3568 || co !== 1'b0 || of !== 1'b0) begin n_fail++; $display("FAIL w_mix got S=%h cout=%b ovf=%b exp acf13568/0/0", s, co, of); end
        send32(32'h0, 32'h1, 1'b0, 1'b1, s, co, of, lat);
        n_cmp++; if (s !== 32'hFFFF_FFFF || co !== 1'b0 || of !== 1'b0) begin n_fail++; $display("FAIL w_sub got S=%h cout=%b ovf=%b exp ffffffff/0/0", s, co, of); end
        send32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, co, of, lat);
`ifdef PIPELINED_CLA_ADDER_SAT_EN
        e = 32'h7FFF_FFFF;
`else
        e = 32'h8000_0000;
`endif
        n_cmp++; if (s !== e || co !== 1'b0 || of !== 1'b1) begin n_fail++; $display("FAIL w_ovf got S=%h cout=%b ovf=%b exp %h/0/1", s, co, of, e); end
    endtask

    task automatic test_random_sweep32();
        logic [31:0] q_s [$];
        logic        q_c [$];
        logic        q_o [$];
        int          q_e [$];
        logic [31:0] a, b, bb, es, xs;
        logic        ci, sb, ec, eo, xc, xo;
        int          xe;
        int          got = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc < 16) begin
                a  = $urandom;
                b  = $urandom;
                ci = 1'($urandom_range(0, 1));
                sb = 1'($urandom_range(0, 1));
                bb = sb ? ~b : b;
                {ec, es} = {1'b0, a} + {1'b0, bb} + {32'd0, (sb | ci)};
                eo = (a[31] == bb[31]) && (es[31] != a[31]);
`ifdef PIPELINED_CLA_ADDER_SAT_EN
                if (eo) es = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
                q_s.push_back(es); q_c.push_back(ec); q_o.push_back(eo); q_e.push_back(cyc + 1);
                a32 = a; b32 = b; cin32 = ci; sub32 = sb; iv32 = 1'b1;
            end else begin
                iv32 = 1'b0;
            end
            @(posedge clk); #1;
            if (ov32 === 1'b1) begin
                got++;
                n_cmp++;
                if (q_s.size() == 0) begin
                    n_fail++; $display("FAIL sweep_extra got S=%h exp no output", s32);
                end else begin
                    xs = q_s.pop_front(); xc = q_c.pop_front(); xo = q_o.pop_front(); xe = q_e.pop_front();
                    if (s32 !== xs || co32 !== xc || of32 !== xo || (cyc + 1) !== xe + 3) begin
                        n_fail++;
                        $display("FAIL sweep_beat%0d got S=%h cout=%b ovf=%b edge=%0d exp S=%h cout=%b ovf=%b edge=%0d",
                                 got, s32, co32, of32, cyc + 1, xs, xc, xo, xe + 3);
                    end
                end
            end
        end
        n_cmp++; if (got !== 16) begin n_fail++; $display("FAIL sweep_count got=%0d exp=16", got); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_async_reset();
        test_wide_directed();
        test_random_sweep32();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead nibbles with inter-nibble carry lookahead.
- Operands are split into STAGES equal slices; each slice is resolved in one cycle and its carry is registered into the next stage.
- Valid/ready handshake on input and output; the result lands in the team's ALU datapath.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4*STAGES.
- STAGES, 2, pipeline depth = latency in cycles; 1 ≤ STAGES ≤ WIDTH/4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  [0:WIDTH-1]  operand A, unsigned; index 0 is the MSB.
- B  input  [0:WIDTH-1]  operand B; index 0 is the MSB.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  1 = A−B (A + ~B + 1), 0 = A+B+cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- S  output  [0:WIDTH-1]  sum/difference; index 0 is the MSB.
- cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset: clk and rst are fixed as above. Asserting rst asynchronously clears all stage valid bits, S, cout, overflow, and out_valid to 0. in_ready is 1 while rst is low. Any in-flight beats are discarded, with no partial output.
- Slicing:
  - Slice k (k=0 is least significant) covers WIDTH/STAGES bits.
  - Stage k computes slice k using 4-bit generate/propagate per nibble, a group lookahead across the slice's nibbles, and the registered carry from stage k−1.
  - Stage 0 takes effcin = sub ? 1 : cin.
- Operand skew: slices k>0 of A and ~B/B travel through k delay registers alongside the pipeline. Completed lower sum slices are likewise delayed so all of S emerges together.
- Latency:
  - The beat accepted on edge N (in_valid & in_ready) appears with out_valid=1 after edge N+STAGES−1, visible from the following cycle.
  - Throughput is 1 beat/cycle when out_ready=1.
- Handshake:
  - Global advance: adv = !out_valid | out_ready, and in_ready = adv.
  - When adv=0, every stage register, including valid bits, holds.
  - When adv=1, each stage valid takes the previous stage valid; stage 0 takes in_valid.
  - Bubbles propagate as valid=0, and stage data may be don't-care.
  - S, cout, and overflow are stable while out_valid=1 and out_ready=0.
- Arithmetic:
  - Full sum = A + (sub ? ~B : B) + effcin, modulo 2^WIDTH.
  - cout is the carry out of bit index 0.
  - overflow = carry into MSB XOR carry out of MSB.
- Simultaneous events: an input accept and an output drain in the same cycle are both legal and complete together. rst overrides everything.
- STAGES=1: purely a registered single-cycle CLA; out_valid follows the accepted beat after one edge.

Optional Feature:
- Macro: PIPELINED_CLA_ADDER_SAT_EN.
- Defined: when overflow=1, S saturates to the signed extreme instead of wrapping. The positive max 0111…1 is used when operand A's sign bit is 0, otherwise the negative min 1000…0. overflow still reports 1, and cout is unchanged.
- Undefined: S wraps modulo 2^WIDTH. The saturation logic is absent.

Test Plan:
- WIDTH=16, STAGES=2, sub=0: A=16'h5555, B=16'h5555, cin=0, out_ready=1 → after 2 cycles S=16'hAAAA, cout=0, overflow=1. With SAT_EN, S=16'h7FFF.
- A=16'hFFFF, B=16'h0001, cin=0, sub=0 → S=16'h0000, cout=1, overflow=0. This proves the carry ripples across the stage boundary.
- sub=1, A=16'h0003, B=16'h0005 (cin=1 ignored) → S=16'hFFFE, cout=0, overflow=0. Then A=16'h0005, B=16'h0003 → S=16'h0002, cout=1.
- Back-to-back beats 16'h0001+16'h0001 and 16'h00FF+16'h0001, followed by out_ready=0 for 3 cycles:
  - Results 16'h0002, then 16'h0100, emerge in order.
  - The output holds stable while stalled, and in_ready=0 during the stall.
  - No beat is lost or duplicated.
- Assert rst asynchronously (mid-clock) while 2 beats are in flight → out_valid=0 and S=0 immediately. After release, no stale results appear, and a new beat 16'h1234+16'h1111 yields 16'h2345.
- Sweep STAGES=4, WIDTH=32 with random operands against a behavioural model → every result matches, and latency is exactly 4 cycles.
